// File: rtl/piton_mem_bridge_if.sv
// OpenPiton memory port: request channel (valid/ready) plus response channel
// (one-cycle valid pulse). The bridge drives the request side as master.
interface piton_mem_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  piton_req_val;
   logic                  piton_req_rdy;
   logic                  piton_req_rw;
   logic [ADDR_W-1:0]     piton_req_addr;
   logic [DATA_W-1:0]     piton_req_data;
   logic [DATA_W/8-1:0]   piton_req_be;
   logic                  piton_resp_val;
   logic [DATA_W-1:0]     piton_resp_data;

   modport master (
      output piton_req_val, piton_req_rw, piton_req_addr, piton_req_data, piton_req_be,
      input  piton_req_rdy, piton_resp_val, piton_resp_data
   );

   modport slave (
      input  piton_req_val, piton_req_rw, piton_req_addr, piton_req_data, piton_req_be,
      output piton_req_rdy, piton_resp_val, piton_resp_data
   );
endinterface

// File: rtl/piton_mem_bridge.sv
// piton_mem_bridge: turns the pipe6 load/store request into a single
// valid/ready transaction on the OpenPiton port and stalls the pipe until
// the response returns. Optional WAIT timeout: define PITON_TIMEOUT_EN.
module piton_mem_bridge #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                gwe6,
   input  logic                rd6,
   input  logic                bw06,
   input  logic                bw16,
   input  logic                bw26,
   input  logic                bw36,
   input  logic [ADDR_W-1:0]   addr6,
   input  logic [DATA_W-1:0]   data_in6,
   piton_mem_bridge_if.master  bus,
   output logic                mem_stall,
   output logic                mem_done,
   output logic [DATA_W-1:0]   piton_out6,
   output logic                access_fault
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t                state_q, state_d;
   logic                  rw_q, rw_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic [DATA_W/8-1:0]   be_q, be_d;
   logic [DATA_W-1:0]     out_q, out_d;
   logic                  req;
   logic                  unused_ok;

   assign req = gwe6 | rd6;

`ifdef PITON_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;
   logic             timeout;

   // Count of completed WAIT cycles; the last allowed one forces DONE.
   assign timeout      = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign access_fault = fault_q;
   assign unused_ok    = ^addr6[1:0];
`else
   assign access_fault = 1'b0;
   assign unused_ok    = ^addr6[1:0] ^ (TIMEOUT_CYCLES != 0);
`endif

   // Next-state and datapath capture; every register holds by default.
   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      data_d  = data_q;
      be_d    = be_q;
      out_d   = out_q;
`ifdef PITON_TIMEOUT_EN
      cnt_d   = cnt_q;
      fault_d = fault_q;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               // gwe6 wins when both are asserted
               rw_d    = gwe6;
               addr_d  = {addr6[ADDR_W-1:2], 2'b00};
               data_d  = data_in6;
               be_d    = gwe6 ? {bw36, bw26, bw16, bw06} : '1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.piton_req_rdy) begin
               state_d = WAIT;
`ifdef PITON_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         WAIT: begin
            if (bus.piton_resp_val) begin
               state_d = DONE;
               if (!rw_q) out_d = bus.piton_resp_data;
            end
`ifdef PITON_TIMEOUT_EN
            else if (timeout) begin
               state_d = DONE;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         DONE: begin
            // inputs still belong to the retiring instruction: ignore them
            state_d = IDLE;
`ifdef PITON_TIMEOUT_EN
            fault_d = 1'b0;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latched request fields; reset abandons any access.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         be_q    <= '0;
         out_q   <= '0;
`ifdef PITON_TIMEOUT_EN
         cnt_q   <= '0;
         fault_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         be_q    <= be_d;
         out_q   <= out_d;
`ifdef PITON_TIMEOUT_EN
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
`endif
      end
   end

   assign bus.piton_req_val  = (state_q == REQ);
   assign bus.piton_req_rw   = rw_q;
   assign bus.piton_req_addr = addr_q;
   assign bus.piton_req_data = data_q;
   assign bus.piton_req_be   = be_q;

   // Stall is combinational so the pipe freezes in the detect cycle;
   // it drops in DONE so the pipe advances at the end of DONE.
   assign mem_stall  = ((state_q == IDLE) & req) | (state_q == REQ) | (state_q == WAIT);
   assign mem_done   = (state_q == DONE);
   assign piton_out6 = out_q;

endmodule
